// File: rtl/sparse_chunk_encoder.sv
// sparse_chunk_encoder: compacts a dense chunk into sparsemap + packed nonzero bytes and streams it to a ping-pong buffer.
// Optional channel padding is enabled by defining SPARSE_ENC_CH_PAD_EN (adds ch_num_i).
module sparse_chunk_encoder #(
    parameter int MEM_SIZE = 128,
    parameter int BUS_SIZE = 32
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic [BUS_SIZE-1:0][7:0]               dense_dat_i,
    input  logic                                   dense_valid_i,
    output logic                                   dense_ready_o,
    input  logic                                   buf_free_i,
`ifdef SPARSE_ENC_CH_PAD_EN
    input  logic [$clog2(MEM_SIZE+1)-1:0]          ch_num_i,
`endif
    output logic [BUS_SIZE-1:0]                    sparsemap_o,
    output logic [BUS_SIZE-1:0][7:0]               nonzero_data_o,
    output logic                                   wr_valid_o,
    output logic [(MEM_SIZE/BUS_SIZE > 1 ? $clog2(MEM_SIZE/BUS_SIZE) : 1)-1:0] wr_count_o,
    output logic                                   wr_sel_o,
    output logic [$clog2(MEM_SIZE+1)-1:0]          nz_count_o,
    output logic                                   chunk_done_o
);
    localparam int BEATS = MEM_SIZE / BUS_SIZE;
    localparam int CW    = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam int NW    = $clog2(MEM_SIZE + 1);
    localparam int MW    = MEM_SIZE > 1 ? $clog2(MEM_SIZE) : 1;
    localparam int PW    = $clog2(BUS_SIZE + 1);

    typedef enum logic [1:0] {COLLECT, WAIT_GRANT, STREAM} state_t;

    state_t                  r_state, w_next;
    logic [CW-1:0]           r_beat;
    logic [NW-1:0]           r_fill;
    logic [BUS_SIZE-1:0]     r_map [BEATS];
    logic [7:0]              r_packed [MEM_SIZE];
    logic                    w_accept, w_last_wr;
    logic [BUS_SIZE-1:0]     w_nz;
    logic [BUS_SIZE-1:0][7:0] w_byte;
    logic [PW-1:0]           w_pre [BUS_SIZE];
    logic [PW-1:0]           w_acc;
    logic [MW-1:0]           w_idx [BUS_SIZE];
    logic [CW-1:0]           w_rd;
    logic [BUS_SIZE-1:0]     w_rd_map;
    logic [BUS_SIZE-1:0][7:0] w_rd_dat;

`ifdef SPARSE_ENC_CH_PAD_EN
    logic [NW-1:0]           r_ch_num, w_ch;
    // the channel limit is taken live until beat 0 is accepted, then held for the rest of the chunk
    assign w_ch = (r_beat == '0) ? ch_num_i : r_ch_num;
`endif

    assign w_accept  = (r_state == COLLECT) && dense_ready_o && dense_valid_i;
    assign w_last_wr = (r_state == STREAM) && (wr_count_o == CW'(BEATS - 1));
    assign w_rd      = (r_state == STREAM) ? wr_count_o + 1'b1 : '0;

    // byte masking (channel padding) and nonzero detection
    always_comb begin
        for (int b = 0; b < BUS_SIZE; b++) begin
            w_byte[b] = dense_dat_i[b];
`ifdef SPARSE_ENC_CH_PAD_EN
            if (int'(r_beat) * BUS_SIZE + b >= int'(w_ch)) w_byte[b] = 8'h00;
`endif
            w_nz[b] = |w_byte[b];
        end
    end

    // exclusive prefix popcount gives each nonzero byte its packed slot
    always_comb begin
        w_acc = '0;
        for (int b = 0; b < BUS_SIZE; b++) begin
            w_pre[b] = w_acc;
            w_idx[b] = r_fill[MW-1:0] + MW'(w_acc);
            w_acc    = w_acc + PW'(w_nz[b]);
        end
    end

    // read side: bytes past the fill level are masked so stale storage never leaks out
    always_comb begin
        w_rd_map = r_map[w_rd];
        for (int j = 0; j < BUS_SIZE; j++)
            w_rd_dat[j] = (int'(w_rd) * BUS_SIZE + j < int'(r_fill)) ? r_packed[MW'(int'(w_rd) * BUS_SIZE + j)] : 8'h00;
    end

    // next-state logic
    always_comb begin
        w_next = (w_accept && r_beat == CW'(BEATS - 1)) ? WAIT_GRANT :
                 (r_state == WAIT_GRANT && buf_free_i)   ? STREAM     :
                 w_last_wr                               ? COLLECT    : r_state;
    end

    // state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= COLLECT;
        else         r_state <= w_next;
    end

    // beat counter and fill level
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_beat <= '0;
            r_fill <= '0;
`ifdef SPARSE_ENC_CH_PAD_EN
            r_ch_num <= '0;
`endif
        end else if (w_last_wr) begin
            r_beat <= '0;
            r_fill <= '0;
        end else if (w_accept) begin
            r_beat <= (r_beat == CW'(BEATS - 1)) ? '0 : r_beat + 1'b1;
            r_fill <= r_fill + NW'(w_acc);
`ifdef SPARSE_ENC_CH_PAD_EN
            if (r_beat == '0) r_ch_num <= ch_num_i;
`endif
        end
    end

    // map and packed storage need no reset: every map beat is rewritten and reads are fill-masked
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_map[r_beat] <= w_nz;
            for (int b = 0; b < BUS_SIZE; b++)
                if (w_nz[b]) r_packed[w_idx[b]] <= w_byte[b];
        end
    end

    // registered outputs, loaded from the next-state view
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dense_ready_o  <= 1'b0;
            wr_valid_o     <= 1'b0;
            wr_count_o     <= '0;
            wr_sel_o       <= 1'b0;
            sparsemap_o    <= '0;
            nonzero_data_o <= '0;
            nz_count_o     <= '0;
            chunk_done_o   <= 1'b0;
        end else begin
            dense_ready_o  <= w_next == COLLECT;
            wr_valid_o     <= w_next == STREAM;
            wr_count_o     <= (w_next == STREAM) ? w_rd : '0;
            sparsemap_o    <= (w_next == STREAM) ? w_rd_map : '0;
            nonzero_data_o <= (w_next == STREAM) ? w_rd_dat : '0;
            chunk_done_o   <= w_last_wr;
            if (w_last_wr) begin
                nz_count_o <= r_fill;
                wr_sel_o   <= ~wr_sel_o;
            end
        end
    end
endmodule

// File: tb/tb_sparse_chunk_encoder.sv
// tb_sparse_chunk_encoder: directed chunks with a queue scoreboard for write beats and chunk completions.
module tb_sparse_chunk_encoder;
    typedef struct packed {
        logic [31:0]      map;
        logic [31:0][7:0] dat;
        logic [1:0]       cnt;
        logic             sel;
    } exp_t;
    typedef struct packed {
        logic [7:0] nz;
        logic       sel;
    } done_t;

    logic             clk = 0;
    logic             rst_n;
    logic [31:0][7:0] dense_dat;
    logic             dense_valid;
    logic             dense_ready;
    logic             buf_free;
    logic [31:0]      sparsemap;
    logic [31:0][7:0] nonzero_data;
    logic             wr_valid;
    logic [1:0]       wr_count;
    logic             wr_sel;
    logic [7:0]       nz_count;
    logic             chunk_done;
`ifdef SPARSE_ENC_CH_PAD_EN
    logic [7:0]       ch_num = 8'd128;
`endif

    exp_t  q[$];
    done_t dq[$];
    exp_t  e;
    done_t d;
    int    n_checks = 0;
    int    n_fail = 0;
    logic  exp_sel = 1'b0;
    logic [127:0][7:0] c;

    sparse_chunk_encoder dut (
        .clk_i(clk), .rst_ni(rst_n), .dense_dat_i(dense_dat), .dense_valid_i(dense_valid),
        .dense_ready_o(dense_ready), .buf_free_i(buf_free),
`ifdef SPARSE_ENC_CH_PAD_EN
        .ch_num_i(ch_num),
`endif
        .sparsemap_o(sparsemap), .nonzero_data_o(nonzero_data), .wr_valid_o(wr_valid),
        .wr_count_o(wr_count), .wr_sel_o(wr_sel), .nz_count_o(nz_count), .chunk_done_o(chunk_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ready"}, dense_ready, 0);
        chk({tag, "_wr_valid"}, wr_valid, 0);
        chk({tag, "_wr_count"}, wr_count, 0);
        chk({tag, "_wr_sel"}, wr_sel, 0);
        chk({tag, "_map"}, sparsemap, 0);
        chk({tag, "_data"}, nonzero_data, 0);
        chk({tag, "_nz_count"}, nz_count, 0);
        chk({tag, "_done"}, chunk_done, 0);
    endtask

    // reference compaction: walk the whole chunk in order, append each surviving nonzero byte
    task automatic push_exp(input logic [127:0][7:0] ch_dat, input int ch);
        logic [127:0][7:0] pk;
        logic [127:0]      mp;
        int                n;
        exp_t              x;
        done_t             y;
        pk = '0;
        mp = '0;
        n = 0;
        for (int p = 0; p < 128; p++)
            if (p < ch && ch_dat[p] != 8'h00) begin
                mp[p] = 1'b1;
                pk[n] = ch_dat[p];
                n++;
            end
        for (int k = 0; k < 4; k++) begin
            x.map = mp[k*32 +: 32];
            x.dat = pk[k*32 +: 32];
            x.cnt = 2'(k);
            x.sel = exp_sel;
            q.push_back(x);
        end
        y.nz = 8'(n);
        y.sel = ~exp_sel;
        dq.push_back(y);
        exp_sel = ~exp_sel;
    endtask

    task automatic send_chunk(input logic [127:0][7:0] ch_dat);
        for (int k = 0; k < 4; k++) begin
            int w;
            w = 0;
            dense_dat = ch_dat[k*32 +: 32];
            dense_valid = 1'b1;
            while (!dense_ready && w < 50) begin
                @(posedge clk); #1;
                w++;
            end
            if (w >= 50) begin
                n_checks++;
                n_fail++;
                $display("FAIL send_timeout: got ready=0 expected ready=1 within 50 cycles");
            end
            @(posedge clk); #1;
        end
        dense_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while ((q.size() != 0 || dq.size() != 0) && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        if (w >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_timeout: got %0d beats %0d dones pending expected 0", q.size(), dq.size());
        end
        @(posedge clk); #1;
    endtask

    // monitor: pops the scoreboard whenever the DUT presents a beat or a completion
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_valid) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got wr_count=%0d expected no beat", wr_count);
                end else begin
                    e = q.pop_front();
                    chk("beat_map", sparsemap, e.map);
                    chk("beat_data", nonzero_data, e.dat);
                    chk("beat_count", wr_count, e.cnt);
                    chk("beat_sel", wr_sel, e.sel);
                end
            end
            if (chunk_done) begin
                chk("done_wr_valid", wr_valid, 0);
                if (dq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got chunk_done=1 expected 0");
                end else begin
                    d = dq.pop_front();
                    chk("done_nz_count", nz_count, d.nz);
                    chk("done_sel", wr_sel, d.sel);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        dense_valid = 1'b0;
        dense_dat = '0;
        buf_free = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk_reset("reset");
        @(negedge clk) rst_n = 1'b1;
        #1 chk("ready_before_edge", dense_ready, 0);
        @(posedge clk); #1;
        chk("ready_after_reset", dense_ready, 1);

        // all nonzero: byte = position + 1
        for (int p = 0; p < 128; p++) c[p] = 8'(p + 1);
        push_exp(c, 128);
        send_chunk(c);
        wait_idle();

        // all zero
        c = '0;
        push_exp(c, 128);
        send_chunk(c);
        wait_idle();

        // single byte 5 of beat 2
        c = '0;
        c[69] = 8'hA7;
        push_exp(c, 128);
        send_chunk(c);
        wait_idle();

        // grant withheld for 10 cycles, junk valid pulses must not be consumed
        for (int p = 0; p < 128; p++) c[p] = (p % 3 == 0) ? 8'h00 : 8'(p * 7 + 3);
        buf_free = 1'b0;
        push_exp(c, 128);
        send_chunk(c);
        dense_dat = {32{8'hEE}};
        for (int i = 0; i < 10; i++) begin
            chk("gap_ready", dense_ready, 0);
            chk("gap_wr_valid", wr_valid, 0);
            dense_valid = (i % 2 == 0);
            @(posedge clk); #1;
        end
        buf_free = 1'b1;
        dense_valid = 1'b1;
        @(posedge clk); #1;
        chk("stream_start", wr_valid, 1);
        repeat (3) @(posedge clk);
        #1 dense_valid = 1'b0;
        wait_idle();

        // a chunk mixing values, leaves wr_sel=1 and nz_count nonzero before the abort
        for (int p = 0; p < 128; p++) c[p] = (p % 5 == 2) ? 8'(p ^ 8'h5A) : 8'h00;
        push_exp(c, 128);
        send_chunk(c);
        wait_idle();
        chk("pre_abort_sel", wr_sel, 1);

        // abort after three beats of an all-0xFF chunk
        dense_valid = 1'b1;
        dense_dat = {32{8'hFF}};
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk_reset("abort");
        dense_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        exp_sel = 1'b0;
        @(posedge clk); #1;

        c = '0;
        c[0] = 8'h11;
        c[100] = 8'h22;
        push_exp(c, 128);
        send_chunk(c);
        wait_idle();

`ifdef SPARSE_ENC_CH_PAD_EN
        for (int p = 0; p < 128; p++) c[p] = 8'(p + 1);
        ch_num = 8'd40;
        push_exp(c, 40);
        send_chunk(c);
        wait_idle();
        ch_num = 8'd128;
`endif

        chk("final_queue_empty", q.size() + dq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
